// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : freq_meter_pkg
// Brief   : Shared state encoding, clog2 helper and gate constant for freq_meter.
// Revision: 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    CONV = 2'd2
  } state_e;

  localparam int GATE_1S = 100_000_000;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Sequential shift-add-3 binary-to-BCD converter, one bit per clock.
// Revision: 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import freq_meter_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int CW = clog2(IN_W + 1);

  logic [IN_W-1:0]     r_bin;
  logic [4*DIGITS-1:0] r_acc;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] w_adj;

  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // bcd is the next accumulator value, so it is final while done is high
  assign bcd  = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_bin[IN_W-1]};
  assign done = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_bin <= bin;
      r_acc <= '0;
      r_cnt <= CW'(IN_W);
    end else if (r_cnt != '0) begin
      r_acc <= bcd;
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module  : freq_meter
// Brief   : Counts sig_in rising edges over a GATE_CYCLES window, back to back.
//           Optional BCD output enabled by defining FREQ_METER_BCD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_1S,
  parameter int CNT_W       = 27,
  parameter int DIGITS      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sig_in,
  output logic [CNT_W-1:0]    freq,
  output logic                valid,
  output logic                ovf,
  output logic                busy
`ifdef FREQ_METER_BCD_EN
  ,
  output logic [4*DIGITS-1:0] bcd
`endif
);

  localparam int              GW     = (clog2(GATE_CYCLES) < 1) ? 1 : clog2(GATE_CYCLES);
  localparam logic [GW-1:0]   GLAST  = GW'(GATE_CYCLES - 1);
  localparam logic [1:0]      S_IDLE = IDLE;
  localparam logic [1:0]      S_GATE = GATE;

  if (DIGITS < 1) begin : g_bad_digits
    $error("freq_meter: DIGITS must be at least 1");
  end

  logic             r_s1, r_s2, r_s3;
  logic [1:0]       r_state;
  logic [GW-1:0]    r_gcnt;
  logic [CNT_W-1:0] r_ecnt;
  logic             r_sat;
  logic [CNT_W-1:0] r_freq;
  logic             r_ovf;
  logic             r_valid;

  logic             w_edge;
  logic             w_last;
  logic             w_ecnt_max;
  logic [CNT_W-1:0] w_fin_freq;
  logic             w_fin_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge     = r_s2 & ~r_s3;
  assign w_last     = (r_state == S_GATE) && (r_gcnt == GLAST);
  assign w_ecnt_max = &r_ecnt;
  // An edge on the closing cycle still belongs to this gate
  assign w_fin_freq = (w_edge && !w_ecnt_max) ? r_ecnt + CNT_W'(1) : r_ecnt;
  assign w_fin_ovf  = r_sat | (w_edge & w_ecnt_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gcnt  <= '0;
      r_ecnt  <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_GATE: begin
          if (w_last || !en) begin
            r_gcnt  <= '0;
            r_ecnt  <= '0;
            r_sat   <= 1'b0;
            r_state <= en ? S_GATE : S_IDLE;
          end else begin
            r_gcnt <= r_gcnt + GW'(1);
            if (w_edge) begin
              if (w_ecnt_max) begin
                r_sat <= 1'b1;
              end else begin
                r_ecnt <= r_ecnt + CNT_W'(1);
              end
            end
          end
        end
        default: begin
          r_gcnt  <= '0;
          r_ecnt  <= '0;
          r_sat   <= 1'b0;
          r_state <= en ? S_GATE : S_IDLE;
        end
      endcase
    end
  end

`ifdef FREQ_METER_BCD_EN
  if (GATE_CYCLES <= CNT_W + 1) begin : g_gate_too_short
    $error("freq_meter: GATE_CYCLES must exceed CNT_W+1 when BCD is enabled");
  end

  logic [CNT_W-1:0]    r_pfreq;
  logic                r_povf;
  logic [4*DIGITS-1:0] r_bcd;
  logic [4*DIGITS-1:0] w_bcd;
  logic                w_done;

  // The converter works on a latched copy so the next gate starts at once
  bin2bcd_seq #(
    .IN_W   (CNT_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_last),
    .bin   (w_fin_freq),
    .bcd   (w_bcd),
    .done  (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pfreq <= '0;
      r_povf  <= 1'b0;
      r_freq  <= '0;
      r_ovf   <= 1'b0;
      r_bcd   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_last) begin
        r_pfreq <= w_fin_freq;
        r_povf  <= w_fin_ovf;
      end
      if (w_done) begin
        r_freq <= r_pfreq;
        r_ovf  <= r_povf;
        r_bcd  <= w_bcd;
      end
    end
  end

  assign bcd = r_bcd;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq  <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_last) begin
        r_freq <= w_fin_freq;
        r_ovf  <= w_fin_ovf;
      end
    end
  end
`endif

  assign freq  = r_freq;
  assign ovf   = r_ovf;
  assign valid = r_valid;
  assign busy  = (r_state == S_GATE);

endmodule
`default_nettype wire
